// File: rtl/game_sequencer_if.sv
// Game sequencer signal bundle: console inputs (tick strobe, pushbutton
// levels, timer-at-zero levels) and the sequencer's registered outputs.
// Signalling: there is no valid/ready pair. TICK is a one-cycle strobe, PB_*
// and *_ZERO are levels sampled on every rising clock edge, and *_LOAD are
// one-cycle pulses that the timers must accept unconditionally.
interface game_sequencer_if;
  logic       TICK;
  logic       PB_START;
  logic       PB_STOP;
  logic       PB_POSS;
  logic       PB_NEXT;
  logic       GAME_ZERO;
  logic       SHOT_ZERO;
  logic       GAME_EN;
  logic       SHOT_EN;
  logic       GAME_LOAD;
  logic       SHOT_LOAD;
  logic       HORN;
  logic [2:0] PERIOD;
  logic       POSS;
  logic [2:0] STATE;

  // Console / timers side: drives buttons and zero flags, observes controls.
  modport master (
    output TICK, PB_START, PB_STOP, PB_POSS, PB_NEXT, GAME_ZERO, SHOT_ZERO,
    input  GAME_EN, SHOT_EN, GAME_LOAD, SHOT_LOAD, HORN, PERIOD, POSS, STATE
  );

  // Sequencer side.
  modport slave (
    input  TICK, PB_START, PB_STOP, PB_POSS, PB_NEXT, GAME_ZERO, SHOT_ZERO,
    output GAME_EN, SHOT_EN, GAME_LOAD, SHOT_LOAD, HORN, PERIOD, POSS, STATE
  );
endinterface

// File: rtl/game_sequencer.sv
// Basketball game sequencer: tracks play state, period and possession,
// enables the game/shot timers, issues reload pulses and drives the horn.
// The registered state is exported on STATE for observation.
module game_sequencer #(
  parameter int NUM_PERIODS = 4,
  parameter int HORN_TICKS  = 20
) (
  input  logic             CLK,
  input  logic             RST_N,
  game_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LIVE       = 3'd1,
    S_DEAD       = 3'd2,
    S_SHOT_VIOL  = 3'd3,
    S_PERIOD_END = 3'd4,
    S_FINAL      = 3'd5
  } state_t;

  localparam logic [7:0] HORN_CNT    = 8'(HORN_TICKS);
  localparam logic [2:0] LAST_PERIOD = 3'(NUM_PERIODS);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_period;
  logic [2:0] w_period_nxt;
  logic       r_poss;
  logic       w_poss_nxt;
  logic [7:0] r_horn_cnt;
  logic       w_horn_load;
  logic       w_horn_zero;
  logic       r_game_load;
  logic       w_game_load_nxt;
  logic       r_shot_load;
  logic       w_shot_load_nxt;

  // Previous button levels; r_armed stays low for the first post-reset cycle
  // so a button held through reset release only seeds prev, never an event.
  logic r_prev_start;
  logic r_prev_stop;
  logic r_prev_poss;
  logic r_prev_next;
  logic r_armed;

  logic w_ev_start;
  logic w_ev_stop;
  logic w_ev_poss;
  logic w_ev_next;

  assign w_ev_start  = bus.PB_START & ~r_prev_start & r_armed;
  assign w_ev_stop   = bus.PB_STOP  & ~r_prev_stop  & r_armed;
  assign w_ev_poss   = bus.PB_POSS  & ~r_prev_poss  & r_armed;
  assign w_ev_next   = bus.PB_NEXT  & ~r_prev_next  & r_armed;
  assign w_horn_zero = (r_horn_cnt == 8'd0);

  // State, counters, pulses and button history registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_period     <= 3'd1;
      r_poss       <= 1'b0;
      r_horn_cnt   <= 8'd0;
      r_game_load  <= 1'b0;
      r_shot_load  <= 1'b0;
      r_prev_start <= 1'b0;
      r_prev_stop  <= 1'b0;
      r_prev_poss  <= 1'b0;
      r_prev_next  <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_period     <= w_period_nxt;
      r_poss       <= w_poss_nxt;
      r_game_load  <= w_game_load_nxt;
      r_shot_load  <= w_shot_load_nxt;
      r_prev_start <= bus.PB_START;
      r_prev_stop  <= bus.PB_STOP;
      r_prev_poss  <= bus.PB_POSS;
      r_prev_next  <= bus.PB_NEXT;
      r_armed      <= 1'b1;
      if (w_horn_load) begin
        r_horn_cnt <= HORN_CNT;
      end else if (bus.TICK && !w_horn_zero) begin
        r_horn_cnt <= r_horn_cnt - 8'd1;
      end
    end
  end

  // Next-state and pulse decode; LIVE conditions are checked in priority order.
  always_comb begin
    w_state_nxt     = r_state;
    w_period_nxt    = r_period;
    w_poss_nxt      = r_poss;
    w_game_load_nxt = 1'b0;
    w_shot_load_nxt = 1'b0;
    w_horn_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ev_start) w_state_nxt = S_LIVE;
      end
      S_LIVE: begin
        if (bus.GAME_ZERO) begin
          w_state_nxt = S_PERIOD_END;
          w_horn_load = 1'b1;
        end else if (bus.SHOT_ZERO) begin
          w_state_nxt     = S_SHOT_VIOL;
          w_poss_nxt      = ~r_poss;
          w_shot_load_nxt = 1'b1;
          w_horn_load     = 1'b1;
        end else if (w_ev_stop) begin
          w_state_nxt = S_DEAD;
        end else if (w_ev_poss) begin
          w_poss_nxt      = ~r_poss;
          w_shot_load_nxt = 1'b1;
        end
      end
      S_DEAD: begin
        if (w_ev_poss) begin
          w_poss_nxt      = ~r_poss;
          w_shot_load_nxt = 1'b1;
        end
        if (w_ev_start && !w_ev_stop) w_state_nxt = S_LIVE;
      end
      S_SHOT_VIOL: begin
        if (w_horn_zero) w_state_nxt = S_DEAD;
      end
      S_PERIOD_END: begin
        if (w_horn_zero) begin
          if (r_period == LAST_PERIOD) begin
            w_state_nxt = S_FINAL;
          end else if (w_ev_next) begin
            w_state_nxt     = S_IDLE;
            w_period_nxt    = r_period + 3'd1;
            w_game_load_nxt = 1'b1;
            w_shot_load_nxt = 1'b1;
          end
        end
      end
      S_FINAL: begin
        w_state_nxt = S_FINAL;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.GAME_EN   = (r_state == S_LIVE);
  assign bus.SHOT_EN   = (r_state == S_LIVE);
  assign bus.GAME_LOAD = r_game_load;
  assign bus.SHOT_LOAD = r_shot_load;
  assign bus.HORN      = ~w_horn_zero;
  assign bus.PERIOD    = r_period;
  assign bus.POSS      = r_poss;
  assign bus.STATE     = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios followed by random
// console activity, every cycle checked against a rule-level game model.
module tb_game_sequencer;
  localparam int NP = 4;
  localparam int HT = 20;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  game_sequencer_if bus ();

  game_sequencer #(.NUM_PERIODS(NP), .HORN_TICKS(HT)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int tick_div = 2;
  int horn_ticks = 0;

  // ---------------- game model ----------------
  // Play phases: 0 idle, 1 live, 2 dead, 3 shot violation, 4 period end, 5 final.
  int m_phase  = 0;
  int m_period = 1;
  int m_team   = 0;
  int m_horn   = 0;
  int m_gload  = 0;
  int m_sload  = 0;
  bit m_seen_reset_exit = 0;
  bit m_last_pb[4];

  // Apply one clock edge worth of game rules to the model.
  task automatic model_edge();
    bit pb[4];
    bit ev[4];
    bit horn_start;
    pb[0] = bus.PB_START; pb[1] = bus.PB_STOP; pb[2] = bus.PB_POSS; pb[3] = bus.PB_NEXT;
    if (!RST_N) begin
      m_phase = 0; m_period = 1; m_team = 0; m_horn = 0;
      m_gload = 0; m_sload = 0; m_seen_reset_exit = 0;
      foreach (m_last_pb[i]) m_last_pb[i] = 0;
      return;
    end
    foreach (ev[i]) ev[i] = pb[i] && !m_last_pb[i] && m_seen_reset_exit;
    m_gload = 0;
    m_sload = 0;
    horn_start = 0;
    if (m_phase == 0) begin
      if (ev[0]) m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus.GAME_ZERO) begin
        m_phase = 4; horn_start = 1;
      end else if (bus.SHOT_ZERO) begin
        m_phase = 3; m_team = 1 - m_team; m_sload = 1; horn_start = 1;
      end else if (ev[1]) begin
        m_phase = 2;
      end else if (ev[2]) begin
        m_team = 1 - m_team; m_sload = 1;
      end
    end else if (m_phase == 2) begin
      if (ev[2]) begin m_team = 1 - m_team; m_sload = 1; end
      if (ev[0] && !ev[1]) m_phase = 1;
    end else if (m_phase == 3) begin
      if (m_horn == 0) m_phase = 2;
    end else if (m_phase == 4) begin
      if (m_horn == 0) begin
        if (m_period == NP) m_phase = 5;
        else if (ev[3]) begin
          m_period++; m_gload = 1; m_sload = 1; m_phase = 0;
        end
      end
    end
    if (horn_start) m_horn = HT;
    else if (bus.TICK && m_horn > 0) m_horn--;
    foreach (m_last_pb[i]) m_last_pb[i] = pb[i];
    m_seen_reset_exit = 1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",     8'(bus.STATE),     8'(m_phase));
    chk("period",    8'(bus.PERIOD),    8'(m_period));
    chk("poss",      8'(bus.POSS),      8'(m_team));
    chk("horn",      8'(bus.HORN),      8'(m_horn != 0));
    chk("game_en",   8'(bus.GAME_EN),   8'(m_phase == 1));
    chk("shot_en",   8'(bus.SHOT_EN),   8'(m_phase == 1));
    chk("game_load", 8'(bus.GAME_LOAD), 8'(m_gload));
    chk("shot_load", 8'(bus.SHOT_LOAD), 8'(m_sload));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    bus.TICK = ($urandom_range(0, tick_div - 1) == 0);
    if (bus.HORN === 1'b1 && bus.TICK) horn_ticks++;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  // which: 0 start, 1 stop, 2 poss, 3 next. Button is high for one edge.
  task automatic press(input int which);
    case (which)
      0: bus.PB_START = 1'b1;
      1: bus.PB_STOP  = 1'b1;
      2: bus.PB_POSS  = 1'b1;
      default: bus.PB_NEXT = 1'b1;
    endcase
    cycle();
    bus.PB_START = 1'b0; bus.PB_STOP = 1'b0; bus.PB_POSS = 1'b0; bus.PB_NEXT = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin cycle(); n++; end
    chk("wait_phase", 8'(bus.STATE), 8'(ph));
  endtask

  task automatic wait_horn_off(input int budget);
    int n = 0;
    while (m_horn != 0 && n < budget) begin cycle(); n++; end
    chk("wait_horn_off", 8'(bus.HORN), 8'd0);
  endtask

  task automatic end_period();
    press(0);
    cycle();
    bus.GAME_ZERO = 1'b1; cycle(); bus.GAME_ZERO = 1'b0;
    wait_horn_off(500);
  endtask

  // Whole-run watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bus.TICK = 0; bus.PB_START = 0; bus.PB_STOP = 0; bus.PB_POSS = 0;
    bus.PB_NEXT = 0; bus.GAME_ZERO = 0; bus.SHOT_ZERO = 0;

    // Reset with START held through the release: no event may result.
    RST_N = 1'b0; bus.PB_START = 1'b1;
    repeat (3) cycle();
    chk("rst_state", 8'(bus.STATE), 8'd0);
    chk("rst_period", 8'(bus.PERIOD), 8'd1);
    chk("rst_horn", 8'(bus.HORN), 8'd0);
    RST_N = 1'b1;
    repeat (3) cycle();
    chk("held_pb_no_event", 8'(bus.STATE), 8'd0);
    bus.PB_START = 1'b0;
    cycle();

    // START -> LIVE.
    press(0);
    chk("start_live", 8'(bus.STATE), 8'd1);
    chk("start_en", 8'({bus.GAME_EN, bus.SHOT_EN}), 8'd3);
    chk("start_period", 8'(bus.PERIOD), 8'd1);
    chk("start_poss", 8'(bus.POSS), 8'd0);

    // Shot clock violation: horn for HT ticks, then DEAD.
    bus.SHOT_ZERO = 1'b1; cycle(); bus.SHOT_ZERO = 1'b0;
    chk("sv_state", 8'(bus.STATE), 8'd3);
    chk("sv_poss", 8'(bus.POSS), 8'd1);
    chk("sv_sload", 8'(bus.SHOT_LOAD), 8'd1);
    horn_ticks = 0;
    cycle();
    chk("sv_sload_1cyc", 8'(bus.SHOT_LOAD), 8'd0);
    wait_phase(2, 500);
    chk("sv_horn_ticks", 8'(horn_ticks), 8'(HT));

    // DEAD: possession change, then back to LIVE.
    press(2);
    chk("dead_poss", 8'(bus.POSS), 8'd0);
    chk("dead_sload", 8'(bus.SHOT_LOAD), 8'd1);
    press(0);
    chk("dead_start", 8'(bus.STATE), 8'd1);

    // START and STOP together in LIVE -> DEAD.
    bus.PB_START = 1'b1; bus.PB_STOP = 1'b1; cycle();
    bus.PB_START = 1'b0; bus.PB_STOP = 1'b0;
    chk("startstop_dead", 8'(bus.STATE), 8'd2);
    cycle();
    press(0);
    press(2);
    chk("live_poss", 8'(bus.POSS), 8'd1);
    chk("live_poss_sload", 8'(bus.SHOT_LOAD), 8'd1);

    // GAME_ZERO with SHOT_ZERO: period end only.
    bus.GAME_ZERO = 1'b1; bus.SHOT_ZERO = 1'b1; cycle();
    bus.GAME_ZERO = 1'b0; bus.SHOT_ZERO = 1'b0;
    chk("pe_state", 8'(bus.STATE), 8'd4);
    chk("pe_poss", 8'(bus.POSS), 8'd1);
    chk("pe_no_sload", 8'(bus.SHOT_LOAD), 8'd0);
    horn_ticks = 0;
    cycle();
    press(3);
    chk("pe_next_ignored", 8'(bus.PERIOD), 8'd1);
    cycle();
    wait_horn_off(500);
    chk("pe_horn_ticks", 8'(horn_ticks), 8'(HT));
    press(3);
    chk("next_period", 8'(bus.PERIOD), 8'd2);
    chk("next_loads", 8'({bus.GAME_LOAD, bus.SHOT_LOAD}), 8'd3);
    chk("next_idle", 8'(bus.STATE), 8'd0);
    cycle();
    chk("next_loads_1cyc", 8'({bus.GAME_LOAD, bus.SHOT_LOAD}), 8'd0);

    // Period 2 -> 3, then reset mid-horn in period 3.
    end_period(); press(3);
    press(0); cycle();
    bus.GAME_ZERO = 1'b1; cycle(); bus.GAME_ZERO = 1'b0;
    cycle(); cycle();
    chk("p3_pe", 8'(bus.PERIOD), 8'd3);
    chk("p3_horn", 8'(bus.HORN), 8'd1);
    RST_N = 1'b0; cycle(); RST_N = 1'b1;
    chk("midhorn_rst_state", 8'(bus.STATE), 8'd0);
    chk("midhorn_rst_period", 8'(bus.PERIOD), 8'd1);
    chk("midhorn_rst_horn", 8'(bus.HORN), 8'd0);
    cycle();

    // Full game to FINAL.
    tick_div = 1;
    for (int p = 1; p < NP; p++) begin end_period(); press(3); end
    end_period();
    wait_phase(5, 50);
    chk("final_period", 8'(bus.PERIOD), 8'(NP));
    press(3); press(0); press(2); press(1); cycle();
    chk("final_hold_state", 8'(bus.STATE), 8'd5);
    chk("final_hold_period", 8'(bus.PERIOD), 8'(NP));
    RST_N = 1'b0; cycle(); RST_N = 1'b1;
    chk("final_rst", 8'(bus.STATE), 8'd0);

    // Random console activity.
    tick_div = 3;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.PB_START = ~bus.PB_START;
      if ($urandom_range(0, 5) == 0) bus.PB_STOP  = ~bus.PB_STOP;
      if ($urandom_range(0, 4) == 0) bus.PB_POSS  = ~bus.PB_POSS;
      if ($urandom_range(0, 2) == 0) bus.PB_NEXT  = ~bus.PB_NEXT;
      bus.GAME_ZERO = ($urandom_range(0, 29) == 0);
      bus.SHOT_ZERO = ($urandom_range(0, 19) == 0);
      RST_N = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter NUM_PERIODS, default 4: number of regulation periods; valid range 1..7.
REQ-002 Parameter HORN_TICKS, default 20: horn duration in TICK strobes (2.0 s at 10 Hz); valid range 1..255.
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset.
REQ-005 TICK  input  1  one-cycle decisecond strobe (10 Hz), synchronous to CLK.
REQ-006 PB_START / PB_STOP  input  1 each  pushbutton levels: start / stop play.
REQ-007 PB_POSS  input  1  pushbutton level: possession change.
REQ-008 PB_NEXT  input  1  pushbutton level: advance to next period.
REQ-009 GAME_ZERO / SHOT_ZERO  input  1 each  level: game timer at 0:00.0 / shot clock at 0.0.
REQ-010 GAME_EN / SHOT_EN  output  1 each  count enables for the game timer and shot clock.
REQ-011 GAME_LOAD / SHOT_LOAD  output  1 each  one-cycle reload pulses (game 12:00.0, shot 24.0).
REQ-012 HORN  output  1  horn drive.
REQ-013 PERIOD  output  3  current period, 1-based.
REQ-014 POSS  output  1  possession: 0 = team 1, 1 = team 2.
REQ-015 STATE  output  3  state code.

Function
REQ-016 Each PB input SHALL be edge-detected with a registered previous value; event = PB & ~prev.
REQ-017 The states and STATE codes SHALL be IDLE=0, LIVE=1, DEAD=2, SHOT_VIOL=3, PERIOD_END=4, FINAL=5. Codes 6 and 7 SHALL return to IDLE on the next clock.
REQ-018 GAME_EN and SHOT_EN SHALL be 1 only in LIVE and SHALL be decoded from the registered state.
REQ-019 Every state change and output pulse SHALL appear on the clock edge after the cycle in which the triggering event is sampled (1-cycle latency). Each pulse SHALL last exactly one cycle.
REQ-020 IDLE: a START event SHALL go to LIVE.
REQ-021 LIVE priority, highest first:
- GAME_ZERO -> PERIOD_END.
- SHOT_ZERO -> SHOT_VIOL, POSS toggles.
- STOP event -> DEAD.
- POSS event -> POSS toggles, SHOT_LOAD pulses, remain in LIVE.
REQ-022 GAME_ZERO and SHOT_ZERO in the same cycle SHALL give PERIOD_END with no POSS toggle and no SHOT_LOAD.
REQ-023 In LIVE, START and STOP events in the same cycle SHALL give DEAD.
REQ-024 In LIVE, a POSS event coincident with any higher-priority condition SHALL be ignored.
REQ-025 DEAD: a START event without a STOP event SHALL go to LIVE. A POSS event SHALL toggle POSS and pulse SHOT_LOAD. Both may occur in the same cycle.
REQ-026 On entry to SHOT_VIOL, SHOT_LOAD SHALL pulse. SHOT_VIOL SHALL exit to DEAD on the cycle after the horn counter reaches 0.
REQ-027 On entry to PERIOD_END and to SHOT_VIOL, the 8-bit horn counter SHALL load HORN_TICKS.
- The counter SHALL decrement on each TICK while nonzero.
- HORN SHALL be 1 exactly while the counter is nonzero.
REQ-028 PERIOD_END, once the horn counter is 0:
- If PERIOD == NUM_PERIODS, go to FINAL.
- Otherwise, a NEXT event SHALL increment PERIOD, pulse GAME_LOAD and SHOT_LOAD together, and go to IDLE.
- NEXT events while HORN = 1 SHALL be ignored.
REQ-029 FINAL SHALL be terminal until reset. All button events in FINAL SHALL be ignored, and PERIOD SHALL hold.
REQ-030 In all states except LIVE and DEAD, PB_POSS events SHALL be ignored.
REQ-031 PERIOD SHALL never exceed NUM_PERIODS and SHALL never wrap.

Reset
REQ-032 When RST_N = 0 at a rising CLK edge, the block SHALL set:
- STATE = IDLE, PERIOD = 1, POSS = 0, horn counter = 0.
- All PB prev registers = 0.
- GAME_EN, SHOT_EN, GAME_LOAD, SHOT_LOAD and HORN = 0.
REQ-033 Reset SHALL take priority over all events, including mid-horn and in FINAL.
REQ-034 A PB held high through reset release SHALL NOT generate an event, because prev is captured from the first post-reset cycle.

Verification
REQ-035 Reset, then START pulse -> STATE = 1 and GAME_EN = SHOT_EN = 1 one cycle later; PERIOD = 1; POSS = 0.
REQ-036 LIVE, SHOT_ZERO = 1 -> STATE = 3, POSS = 1, SHOT_LOAD for 1 cycle; HORN = 1 for 20 TICKs; then STATE = 2.
REQ-037 LIVE, GAME_ZERO and SHOT_ZERO together -> STATE = 4, POSS unchanged, no SHOT_LOAD, HORN for 20 TICKs. After the horn, NEXT -> PERIOD = 2, GAME_LOAD and SHOT_LOAD high in the same cycle, STATE = 0.
REQ-038 Run 4 periods to GAME_ZERO -> after the horn, STATE = 5 and PERIOD = 4. Further NEXT/START events -> no change.
REQ-039 LIVE, START and STOP in the same cycle -> STATE = 2. A POSS event in DEAD -> POSS toggles and SHOT_LOAD pulses. A PB held through reset release -> no event.
REQ-040 RST_N = 0 mid-horn in PERIOD_END with PERIOD = 3 -> next cycle STATE = 0, PERIOD = 1, HORN = 0.
